// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pwm_pkg                                                         |
// | Brief  : Shared types and helpers for the count-driven PWM block.        |
// |          state_t   - duty handshake states                               |
// |          cnt_max   - largest count value for a W-bit counter (2^W-1)     |
// |          duty_max  - largest legal duty for a W-bit counter (2^W)        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package pwm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned duty_max(input int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_seq_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : count_seq_chk                                                   |
// | Brief  : Watches an upstream modulo-2^W count and raises a sticky error  |
// |          when it fails to advance by exactly +1 per clock.               |
// | Ports  : clk     in  clock, rising edge                                  |
// |          rst     in  synchronous active-high reset                       |
// |          cnt     in  W-bit upstream count                                |
// |          seq_err out sticky: count skipped or stalled since reset        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module count_seq_chk #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt,
  output logic         seq_err
);

  logic [W-1:0] prev_q, prev_d;
  logic         have_prev_q, have_prev_d;
  logic         seq_err_q, seq_err_d;
  logic [W-1:0] w_prev_inc;

  // W-bit add wraps 2^W-1 -> 0 on its own, matching the upstream counter.
  assign w_prev_inc = prev_q + W'(1);

  always_comb begin
    prev_d      = cnt;
    have_prev_d = 1'b1;
    seq_err_d   = seq_err_q;
    // The first edge after reset only primes prev; nothing to compare yet.
    if (have_prev_q && (cnt != w_prev_inc)) begin
      seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;

endmodule
`default_nettype wire

// File: rtl/pwm_from_count.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pwm_from_count                                                  |
// | Brief  : PWM generator driven by a free-running modulo-2^W count. A new  |
// |          duty is taken through a valid/ready handshake into a shadow     |
// |          register and only copied into the active duty at the period     |
// |          boundary, so the waveform never glitches mid-period.            |
// | Ports  : clk         in   clock, rising edge                            |
// |          rst         in   synchronous active-high reset                 |
// |          cnt         in   W-bit upstream count                          |
// |          duty_in     in   requested high cycles per period (0..2^W)     |
// |          duty_valid  in   duty_in valid                                 |
// |          duty_ready  out  a new duty can be accepted                    |
// |          duty_active out  duty currently applied                        |
// |          pwm         out  registered PWM output                         |
// |          wrap        out  one-cycle pulse while cnt==0 is presented     |
// |          seq_err     out  sticky upstream sequence error                |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pwm_from_count
  import pwm_pkg::*;
#(
  parameter int W        = 3,
  parameter int DUTY_RST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt,
  input  logic [W:0]   duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic [W:0]   duty_active,
  output logic         pwm,
  output logic         wrap,
  output logic         seq_err
);

  localparam logic [W-1:0] CNT_MAX    = W'(cnt_max(W));
  localparam logic [W:0]   DUTY_MAX   = (W+1)'(duty_max(W));
  localparam logic [W:0]   C_DUTY_RST = (W+1)'(DUTY_RST);

  state_t       state_q, state_d;
  logic [W:0]   shadow_q, shadow_d;
  logic [W:0]   active_q, active_d;
  logic         pwm_q, pwm_d;
  logic         wrap_q, wrap_d;
  logic         w_boundary;
  logic [W:0]   w_duty_sat;

  assign w_boundary = (cnt == CNT_MAX);
  assign w_duty_sat = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= C_DUTY_RST;
      pwm_q    <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      wrap_q   <= wrap_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    // Compared against the duty in force before this edge, so a duty loaded
    // at the boundary first shows up on the cnt==0 compare one edge later.
    pwm_d    = ({1'b0, cnt} < active_q);
    wrap_d   = w_boundary;
    case (state_q)
      IDLE: begin
        // An accept on the boundary cycle only fills the shadow; the copy
        // into active_q waits for the following boundary.
        if (duty_valid) begin
          shadow_d = w_duty_sat;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (w_boundary) begin
          active_d = shadow_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state only; no valid->ready combinational path.
  always_comb begin
    duty_ready = (state_q == IDLE);
  end

  assign duty_active = active_q;
  assign pwm         = pwm_q;
  assign wrap        = wrap_q;

  count_seq_chk #(
    .W (W)
  ) u_seq_chk (
    .clk     (clk),
    .rst     (rst),
    .cnt     (cnt),
    .seq_err (seq_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_pwm_from_count.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_pwm_from_count                                               |
// | Brief  : Self-checking bench for pwm_from_count (W=3, DUTY_RST=0). The   |
// |          bench plays the upstream 3-bit counter and keeps a behavioural  |
// |          model of the expected outputs.                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_pwm_from_count;

  logic       clk;
  logic       rst;
  logic [2:0] cnt;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic [3:0] duty_active;
  logic       pwm;
  logic       wrap;
  logic       seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int m_active, m_shadow, m_prev;
  bit m_pend, m_pwm, m_wrap, m_err, m_have;

  pwm_from_count #(.W(3), .DUTY_RST(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt         (cnt),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .duty_active (duty_active),
    .pwm         (pwm),
    .wrap        (wrap),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: model consumes the pre-edge inputs, then the upstream counter
  // advances. next_cnt >= 0 forces the counter to that value instead.
  task automatic tick(input int next_cnt = -1);
    @(posedge clk);
    if (rst) begin
      m_pwm = 0; m_wrap = 0; m_active = 0; m_pend = 0;
      m_shadow = 0; m_err = 0; m_have = 0;
    end else begin
      m_pwm  = (int'(cnt) < m_active);
      m_wrap = (cnt == 3'd7);
      if (m_have && int'(cnt) != (m_prev + 1) % 8) m_err = 1;
      m_have = 1;
      if (!m_pend && duty_valid) begin
        m_pend   = 1;
        m_shadow = (int'(duty_in) > 8) ? 8 : int'(duty_in);
      end else if (m_pend && cnt == 3'd7) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
    end
    m_prev = int'(cnt);
    #1;
    if (rst) cnt = 3'd0;
    else if (next_cnt >= 0) cnt = 3'(next_cnt);
    else cnt = cnt + 3'd1;
  endtask

  task automatic wait_cnt(input int v);
    int k = 0;
    while (int'(cnt) != v && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (int'(cnt) != v) begin
      n_fail++;
      $display("FAIL wait_cnt: cnt=%0d required %0d", cnt, v);
    end
  endtask

  // Waits for the boundary at which duty d is in force, then counts pwm highs
  // over the next full period.
  task automatic measure(input int d, output int highs, output bit ok);
    int k = 0;
    highs = 0;
    while (!(m_wrap && m_active == d) && k < 40) begin
      tick();
      k++;
    end
    ok = (m_wrap && m_active == d);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pwm === 1'b1) highs++;
    end
  endtask

  task automatic send_duty(input int d);
    duty_valid = 1'b1;
    duty_in    = 4'(d);
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (pwm !== 1'b0 || wrap !== 1'b0 || duty_active !== 4'd0 ||
        duty_ready !== 1'b1 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: pwm=%b wrap=%b active=%0d ready=%b err=%b required 0 0 0 1 0",
               pwm, wrap, duty_active, duty_ready, seq_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (wrap !== (i == 7) || pwm !== 1'b0 || seq_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: wrap=%b pwm=%b err=%b required wrap=%b pwm=0 err=0",
                 i, wrap, pwm, seq_err, (i == 7));
      end
    end
  endtask

  task automatic test_mid_accept();
    int h; bit ok;
    wait_cnt(2);
    send_duty(3);
    n_checks++;
    if (duty_ready !== 1'b0 || duty_active !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_accept_pend: ready=%b active=%0d required 0 0", duty_ready, duty_active);
    end
    wait_cnt(7);
    n_checks++;
    if (duty_active !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_accept_early: active=%0d required 0", duty_active);
    end
    tick();
    n_checks++;
    if (duty_active !== 4'd3 || duty_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_accept_apply: active=%0d ready=%b required 3 1", duty_active, duty_ready);
    end
    measure(3, h, ok);
    n_checks++;
    if (!ok || h != 3) begin
      n_fail++;
      $display("FAIL duty3_highs: highs=%0d sync=%b required 3 1", h, ok);
    end
  endtask

  task automatic test_full_then_zero();
    int h; bit ok;
    send_duty(8);
    measure(8, h, ok);
    n_checks++;
    if (!ok || h != 8) begin
      n_fail++;
      $display("FAIL duty8_highs: highs=%0d sync=%b required 8 1", h, ok);
    end
    send_duty(0);
    // pwm must stay high right up to the boundary that loads the zero duty.
    for (int k = 0; k < 40 && !(m_wrap && m_active == 0); k++) begin
      tick();
      n_checks++;
      if (pwm !== 1'b1) begin
        n_fail++;
        $display("FAIL duty8_hold: pwm=%b required 1", pwm);
      end
    end
    measure(0, h, ok);
    n_checks++;
    if (!ok || h != 0) begin
      n_fail++;
      $display("FAIL duty0_highs: highs=%0d sync=%b required 0 1", h, ok);
    end
  endtask

  task automatic test_saturate();
    int h; bit ok;
    send_duty(12);
    measure(8, h, ok);
    n_checks++;
    if (!ok || duty_active !== 4'd8 || h != 8) begin
      n_fail++;
      $display("FAIL saturate: active=%0d highs=%0d sync=%b required 8 8 1", duty_active, h, ok);
    end
  endtask

  task automatic test_boundary_accept();
    int old_d;
    old_d = m_active;
    wait_cnt(7);
    send_duty(5);
    n_checks++;
    if (duty_active !== 4'(old_d) || duty_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bnd_accept_now: active=%0d ready=%b required %0d 0", duty_active, duty_ready, old_d);
    end
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (duty_active !== 4'(old_d)) begin
      n_fail++;
      $display("FAIL bnd_accept_hold: active=%0d required %0d", duty_active, old_d);
    end
    tick();
    n_checks++;
    if (duty_active !== 4'd5 || duty_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bnd_accept_apply: active=%0d ready=%b required 5 1", duty_active, duty_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in    = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (pwm !== m_pwm || wrap !== m_wrap || duty_ready !== !m_pend ||
          duty_active !== 4'(m_active) || seq_err !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: pwm=%b wrap=%b ready=%b active=%0d err=%b required %b %b %b %0d %b",
                 i, pwm, wrap, duty_ready, duty_active, seq_err,
                 m_pwm, m_wrap, !m_pend, m_active, m_err);
      end
    end
    duty_valid = 1'b0;
  endtask

  task automatic test_seq_err();
    // Forced jump 4 -> 6.
    wait_cnt(4);
    tick(6);
    n_checks++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_early: seq_err=%b required 0", seq_err);
    end
    tick();
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_detect: seq_err=%b required 1", seq_err);
    end
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_sticky: seq_err=%b required 1", seq_err);
    end
    rst = 1'b1;
    send_duty(6);
    tick();
    rst = 1'b0;
    n_checks++;
    if (seq_err !== 1'b0 || duty_active !== 4'd0 || duty_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_clear: err=%b active=%0d ready=%b required 0 0 1", seq_err, duty_active, duty_ready);
    end
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (seq_err !== 1'b0 || duty_active !== 4'd0) begin
      n_fail++;
      $display("FAIL rearm_clean: err=%b active=%0d required 0 0", seq_err, duty_active);
    end
    // Upstream counter reset on its own: 5 -> 0.
    wait_cnt(5);
    tick(0);
    tick();
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL upstream_rst: seq_err=%b required 1", seq_err);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cnt        = 3'd0;
    duty_in    = 4'd0;
    duty_valid = 1'b0;
    test_reset();
    test_mid_accept();
    test_full_then_zero();
    test_saturate();
    test_boundary_accept();
    test_random();
    test_seq_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
